// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back formatting.
// Sub-word load extraction, misalignment detection and write-back source
// selection happen combinationally from the MEM-side inputs. Every output
// comes straight from a register, so the write port is also a clean WB
// forwarding source for EX. A retired-instruction counter runs alongside.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_mem,
  input  logic [DATA_W-1:0]     memaddr_mem,
  input  logic [DATA_W-1:0]     memreaddata_mem,
  input  logic [DATA_W-1:0]     pcplus4_mem,
  input  logic                  regwrite_mem,
  input  logic [1:0]            memtoreg_mem,
  input  logic [2:0]            loadtype_mem,
  input  logic [REG_ADDR_W-1:0] writereg_mem,
  output logic                  valid_wb,
  output logic                  regwrite_wb,
  output logic [REG_ADDR_W-1:0] writereg_wb,
  output logic [DATA_W-1:0]     writedata_wb,
  output logic                  misalign_wb,
  output logic [CNT_W-1:0]      retired_cnt
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  logic [1:0]            byte_off;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_W-1:0]     load_next;
  logic [DATA_W-1:0]     writedata_next;
  logic                  misalign_next;
  logic                  regwrite_next;

  logic                  valid_reg;
  logic                  regwrite_reg;
  logic [REG_ADDR_W-1:0] writereg_reg;
  logic [DATA_W-1:0]     writedata_reg;
  logic                  misalign_reg;
  logic [CNT_W-1:0]      cnt_reg;

  assign byte_off  = memaddr_mem[1:0];
  // Little-endian lane picks: byte lane by the low two address bits,
  // halfword lane by address bit 1.
  assign load_byte = memreaddata_mem[8*byte_off +: 8];
  assign load_half = memreaddata_mem[16*byte_off[1] +: 16];

  // Sub-word extraction and misalignment detection for the load path
  always_comb begin
    load_next     = memreaddata_mem;
    misalign_next = 1'b0;
    case (loadtype_mem)
      LT_LB:  load_next = {{(DATA_W-8){load_byte[7]}}, load_byte};
      LT_LBU: load_next = {{(DATA_W-8){1'b0}}, load_byte};
      LT_LH: begin
        load_next     = {{(DATA_W-16){load_half[15]}}, load_half};
        misalign_next = byte_off[0];
      end
      LT_LHU: begin
        load_next     = {{(DATA_W-16){1'b0}}, load_half};
        misalign_next = byte_off[0];
      end
      default: begin
        // Unused encodings behave as lw.
        load_next     = memreaddata_mem;
        misalign_next = (byte_off != 2'b00);
      end
    endcase
    // Alignment only matters when the instruction is actually a load.
    if (memtoreg_mem != SRC_LOAD) begin
      misalign_next = 1'b0;
    end
  end

  // Write-back source select and register-file write enable
  always_comb begin
    case (memtoreg_mem)
      SRC_LOAD: writedata_next = load_next;
      SRC_PC4:  writedata_next = pcplus4_mem;
      default:  writedata_next = memaddr_mem;  // 00 and reserved 11
    endcase
    regwrite_next = valid_mem & regwrite_mem & ~misalign_next &
                    (writereg_mem != '0);
  end

  // Pipeline register: reset > flush > stall > capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg     <= 1'b0;
      regwrite_reg  <= 1'b0;
      writereg_reg  <= '0;
      writedata_reg <= '0;
      misalign_reg  <= 1'b0;
      cnt_reg       <= '0;
    end else if (flush) begin
      // Bubble: kill the control bits, leave address/data for debug.
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      misalign_reg <= 1'b0;
    end else if (!stall) begin
      valid_reg     <= valid_mem;
      regwrite_reg  <= regwrite_next;
      writereg_reg  <= writereg_mem;
      writedata_reg <= writedata_next;
      misalign_reg  <= misalign_next;
      if (valid_mem) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign valid_wb     = valid_reg;
  assign regwrite_wb  = regwrite_reg;
  assign writereg_wb  = writereg_reg;
  assign writedata_wb = writedata_reg;
  assign misalign_wb  = misalign_reg;
  assign retired_cnt  = cnt_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: one 32-bit-counter instance and one
// 4-bit-counter instance driven by the same MEM-side stimulus.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_mem, regwrite_mem;
  logic [31:0] memaddr_mem, memreaddata_mem, pcplus4_mem;
  logic [1:0]  memtoreg_mem;
  logic [2:0]  loadtype_mem;
  logic [4:0]  writereg_mem;

  logic        valid_wb, regwrite_wb, misalign_wb;
  logic [4:0]  writereg_wb;
  logic [31:0] writedata_wb, retired_cnt;

  logic        valid_wb4, regwrite_wb4, misalign_wb4;
  logic [4:0]  writereg_wb4;
  logic [31:0] writedata_wb4;
  logic [3:0]  retired_cnt4;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_mem(valid_mem), .memaddr_mem(memaddr_mem),
    .memreaddata_mem(memreaddata_mem), .pcplus4_mem(pcplus4_mem),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
    .loadtype_mem(loadtype_mem), .writereg_mem(writereg_mem),
    .valid_wb(valid_wb), .regwrite_wb(regwrite_wb),
    .writereg_wb(writereg_wb), .writedata_wb(writedata_wb),
    .misalign_wb(misalign_wb), .retired_cnt(retired_cnt)
  );

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_mem(valid_mem), .memaddr_mem(memaddr_mem),
    .memreaddata_mem(memreaddata_mem), .pcplus4_mem(pcplus4_mem),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
    .loadtype_mem(loadtype_mem), .writereg_mem(writereg_mem),
    .valid_wb(valid_wb4), .regwrite_wb(regwrite_wb4),
    .writereg_wb(writereg_wb4), .writedata_wb(writedata_wb4),
    .misalign_wb(misalign_wb4), .retired_cnt(retired_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] pc4, input logic rw, input logic [1:0] m2r,
                           input logic [2:0] lt, input logic [4:0] wr);
    valid_mem       = v;
    memaddr_mem     = addr;
    memreaddata_mem = rdata;
    pcplus4_mem     = pc4;
    regwrite_mem    = rw;
    memtoreg_mem    = m2r;
    loadtype_mem    = lt;
    writereg_mem    = wr;
  endtask

  // One rising edge, then settle on the falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_wb(input string tag, input logic v, input logic rw, input logic [4:0] wr,
                          input logic [31:0] wd, input logic mis, input logic [31:0] cnt);
    check({tag, ".valid"}, {31'd0, valid_wb}, {31'd0, v});
    check({tag, ".regwrite"}, {31'd0, regwrite_wb}, {31'd0, rw});
    check({tag, ".writereg"}, {27'd0, writereg_wb}, {27'd0, wr});
    check({tag, ".writedata"}, writedata_wb, wd);
    check({tag, ".misalign"}, {31'd0, misalign_wb}, {31'd0, mis});
    check({tag, ".cnt"}, retired_cnt, cnt);
    $display("txn %-10s valid=%0d rw=%0d rd=%0d wd=0x%08h mis=%0d cnt=%0d",
             tag, valid_wb, regwrite_wb, writereg_wb, writedata_wb, misalign_wb, retired_cnt);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    set_instr(1'b1, 32'h10, 32'hFFFF_FFFF, 32'h4, 1'b1, 2'b01, 3'b000, 5'd7);

    // Reset with active-looking inputs: everything stays at zero.
    tick();
    tick();
    check_wb("reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    check("reset.cnt4", {28'd0, retired_cnt4}, 32'd0);

    // 17 valid ALU instructions: the 4-bit counter wraps to 1.
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_instr(1'b1, 32'(i), 32'h0, 32'h0, 1'b1, 2'b00, 3'b000, 5'd1);
      tick();
    end
    check_wb("alu17", 1'b1, 1'b1, 5'd1, 32'd16, 1'b0, 32'd17);
    check("wrap.cnt4", {28'd0, retired_cnt4}, 32'd1);

    // lw aligned
    set_instr(1'b1, 32'h10, 32'h8000_00F1, 32'h0, 1'b1, 2'b01, 3'b000, 5'd8);
    tick();
    check_wb("lw", 1'b1, 1'b1, 5'd8, 32'h8000_00F1, 1'b0, 32'd18);

    // Sub-word loads
    set_instr(1'b1, 32'h13, 32'h8A00_0000, 32'h0, 1'b1, 2'b01, 3'b001, 5'd9);
    tick();
    check_wb("lb", 1'b1, 1'b1, 5'd9, 32'hFFFF_FF8A, 1'b0, 32'd19);
    set_instr(1'b1, 32'h13, 32'h8A00_0000, 32'h0, 1'b1, 2'b01, 3'b010, 5'd10);
    tick();
    check_wb("lbu", 1'b1, 1'b1, 5'd10, 32'h0000_008A, 1'b0, 32'd20);
    set_instr(1'b1, 32'h12, 32'h8A00_0000, 32'h0, 1'b1, 2'b01, 3'b011, 5'd11);
    tick();
    check_wb("lh", 1'b1, 1'b1, 5'd11, 32'hFFFF_8A00, 1'b0, 32'd21);
    set_instr(1'b1, 32'h12, 32'h8A00_0000, 32'h0, 1'b1, 2'b01, 3'b100, 5'd12);
    tick();
    check_wb("lhu", 1'b1, 1'b1, 5'd12, 32'h0000_8A00, 1'b0, 32'd22);
    set_instr(1'b1, 32'h11, 32'h0000_C300, 32'h0, 1'b1, 2'b01, 3'b001, 5'd13);
    tick();
    check_wb("lb_a1", 1'b1, 1'b1, 5'd13, 32'hFFFF_FFC3, 1'b0, 32'd23);

    // Misaligned lh: counted, but no register write.
    set_instr(1'b1, 32'h11, 32'h8A00_0000, 32'h0, 1'b1, 2'b01, 3'b011, 5'd14);
    tick();
    check_wb("lh_mis", 1'b1, 1'b0, 5'd14, 32'h0000_0000, 1'b1, 32'd24);

    // jal link, ALU write to $0, reserved memtoreg 11 as ALU
    set_instr(1'b1, 32'h1234, 32'h5555_5555, 32'h0040_0008, 1'b1, 2'b10, 3'b000, 5'd31);
    tick();
    check_wb("jal", 1'b1, 1'b1, 5'd31, 32'h0040_0008, 1'b0, 32'd25);
    set_instr(1'b1, 32'h1234, 32'h0, 32'h0, 1'b1, 2'b00, 3'b000, 5'd0);
    tick();
    check_wb("wr_r0", 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 32'd26);
    set_instr(1'b1, 32'hCAFE, 32'h777, 32'h999, 1'b1, 2'b11, 3'b000, 5'd5);
    tick();
    check_wb("m2r_11", 1'b1, 1'b1, 5'd5, 32'hCAFE, 1'b0, 32'd27);

    // Stall three cycles with changing inputs: everything frozen.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, 32'(100 + i), 32'h0, 32'h0, 1'b1, 2'b01, 3'b000, 5'(20 + i));
      tick();
      check_wb("stall", 1'b1, 1'b1, 5'd5, 32'hCAFE, 1'b0, 32'd27);
    end

    // Stall + flush: bubble, address/data held, no count.
    flush = 1'b1;
    tick();
    check_wb("stl_flush", 1'b0, 1'b0, 5'd5, 32'hCAFE, 1'b0, 32'd27);

    // Misaligned lw, then a lone flush clears misalign.
    stall = 1'b0; flush = 1'b0;
    set_instr(1'b1, 32'h12, 32'h1122_3344, 32'h0, 1'b1, 2'b01, 3'b000, 5'd9);
    tick();
    check_wb("lw_mis", 1'b1, 1'b0, 5'd9, 32'h1122_3344, 1'b1, 32'd28);
    flush = 1'b1;
    set_instr(1'b1, 32'h40, 32'h0, 32'h0, 1'b1, 2'b00, 3'b000, 5'd4);
    tick();
    check_wb("flush", 1'b0, 1'b0, 5'd9, 32'h1122_3344, 1'b0, 32'd28);
    flush = 1'b0;

    // Invalid MEM slot: captured, but no write and no count.
    set_instr(1'b0, 32'h44, 32'h0, 32'h0, 1'b1, 2'b00, 3'b000, 5'd3);
    tick();
    check_wb("invalid", 1'b0, 1'b0, 5'd3, 32'h44, 1'b0, 32'd28);

    // Reset in the middle of a stall wins, then capture resumes.
    set_instr(1'b1, 32'h48, 32'h0, 32'h0, 1'b1, 2'b00, 3'b000, 5'd6);
    tick();
    check_wb("pre_rst", 1'b1, 1'b1, 5'd6, 32'h48, 1'b0, 32'd29);
    stall = 1'b1; reset = 1'b0;
    tick();
    check_wb("rst_stall", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    check("rst.cnt4", {28'd0, retired_cnt4}, 32'd0);
    stall = 1'b0; reset = 1'b1;
    set_instr(1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b01, 3'b000, 5'd2);
    tick();
    check_wb("resume", 1'b1, 1'b1, 5'd2, 32'hDEAD_BEEF, 1'b0, 32'd1);
    check("resume.cnt4", {28'd0, retired_cnt4}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
